// File: rtl/vote_session_ctrl_if.sv
// Vote request/acknowledge bundle for the three requester classes.
// The requesters hold req and id until they see ack; the session controller returns the acks.
interface vote_session_ctrl_if;
    logic       np_req;
    logic [4:0] np_id;
    logic       np_ack;
    logic       vip_req;
    logic [2:0] vip_id;
    logic       vip_ack;
    logic       vvip_req;
    logic       vvip_ack;

    modport master (
        output np_req, np_id, vip_req, vip_id, vvip_req,
        input  np_ack, vip_ack, vvip_ack
    );

    modport slave (
        input  np_req, np_id, vip_req, vip_id, vvip_req,
        output np_ack, vip_ack, vvip_ack
    );
endinterface

// File: rtl/vote_session_ctrl.sv
// Voting session controller: open/close/publish with a round-robin weighted tally.
// Define VOTE_DUP_STATS_EN to add the dup_cnt and last_class outputs.
module vote_session_ctrl #(
    parameter int WINDOW = 64,
    parameter int W_NP   = 1,
    parameter int W_VIP  = 4,
    parameter int W_VVIP = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                close,
    input  logic [7:0]          threshold,
    vote_session_ctrl_if.slave  votes,
    output logic [7:0]          tally,
    output logic                pass,
    output logic                busy,
    output logic                done
`ifdef VOTE_DUP_STATS_EN
    ,
    output logic [7:0]          dup_cnt,
    output logic [1:0]          last_class
`endif
);

    typedef enum logic [1:0] {IDLE, OPEN, CLOSE, DONE} state_t;

    localparam logic [7:0] TIMER_LAST = 8'(WINDOW - 1);
    localparam logic [7:0] WT_NP      = 8'(W_NP);
    localparam logic [7:0] WT_VIP     = 8'(W_VIP);
    localparam logic [7:0] WT_VVIP    = 8'(W_VVIP);

    state_t      state;
    state_t      state_next;
    logic [31:0] np_seen;
    logic [7:0]  vip_seen;
    logic        vvip_seen;
    logic [7:0]  timer;
    logic [7:0]  thr_latched;
    logic [1:0]  rr_ptr;
    logic        grant_np;
    logic        grant_vip;
    logic        grant_vvip;
    logic        any_grant;
    logic        is_dup;
    logic        open_session;
    logic [1:0]  grant_class;
    logic [7:0]  grant_weight;
    logic [8:0]  tally_sum;

    // rr_ptr names the class with highest priority: 0 normal, 1 VIP, 2 VVIP
    always_comb begin
        grant_np   = 1'b0;
        grant_vip  = 1'b0;
        grant_vvip = 1'b0;
        if (state == OPEN) begin
            case (rr_ptr)
                2'd0: begin
                    if (votes.np_req)         grant_np   = 1'b1;
                    else if (votes.vip_req)   grant_vip  = 1'b1;
                    else if (votes.vvip_req)  grant_vvip = 1'b1;
                end
                2'd1: begin
                    if (votes.vip_req)        grant_vip  = 1'b1;
                    else if (votes.vvip_req)  grant_vvip = 1'b1;
                    else if (votes.np_req)    grant_np   = 1'b1;
                end
                default: begin
                    if (votes.vvip_req)       grant_vvip = 1'b1;
                    else if (votes.np_req)    grant_np   = 1'b1;
                    else if (votes.vip_req)   grant_vip  = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        grant_class  = 2'd0;
        grant_weight = 8'd0;
        is_dup       = 1'b0;
        if (grant_np) begin
            grant_class  = 2'd0;
            grant_weight = WT_NP;
            is_dup       = np_seen[votes.np_id];
        end else if (grant_vip) begin
            grant_class  = 2'd1;
            grant_weight = WT_VIP;
            is_dup       = vip_seen[votes.vip_id];
        end else if (grant_vvip) begin
            grant_class  = 2'd2;
            grant_weight = WT_VVIP;
            is_dup       = vvip_seen;
        end
        any_grant = grant_np | grant_vip | grant_vvip;
        tally_sum = {1'b0, tally} + {1'b0, grant_weight};
    end

    always_comb begin
        state_next   = state;
        open_session = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next   = OPEN;
                    open_session = 1'b1;
                end
            end
            OPEN: begin
                if (close || (timer == TIMER_LAST)) state_next = CLOSE;
            end
            CLOSE: state_next = DONE;
            DONE: begin
                if (start) begin
                    state_next   = OPEN;
                    open_session = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        busy           = (state == OPEN);
        done           = (state == DONE);
        votes.np_ack   = grant_np;
        votes.vip_ack  = grant_vip;
        votes.vvip_ack = grant_vvip;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // A vote taken on the last OPEN edge still lands in the tally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            np_seen     <= '0;
            vip_seen    <= '0;
            vvip_seen   <= 1'b0;
            timer       <= '0;
            thr_latched <= '0;
            rr_ptr      <= 2'd0;
            tally       <= '0;
            pass        <= 1'b0;
        end else if (open_session) begin
            np_seen     <= '0;
            vip_seen    <= '0;
            vvip_seen   <= 1'b0;
            timer       <= '0;
            thr_latched <= threshold;
            tally       <= '0;
        end else if (state == OPEN) begin
            timer <= timer + 8'd1;
            if (any_grant) begin
                rr_ptr <= (grant_class == 2'd2) ? 2'd0 : grant_class + 2'd1;
                if (!is_dup) begin
                    if (grant_np)   np_seen[votes.np_id]   <= 1'b1;
                    if (grant_vip)  vip_seen[votes.vip_id] <= 1'b1;
                    if (grant_vvip) vvip_seen              <= 1'b1;
                    tally <= tally_sum[8] ? 8'hFF : tally_sum[7:0];
                end
            end
        end else if (state == CLOSE) begin
            pass <= (tally >= thr_latched);
        end
    end

`ifdef VOTE_DUP_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dup_cnt    <= '0;
            last_class <= 2'd0;
        end else if (open_session) begin
            dup_cnt <= '0;
        end else if (any_grant) begin
            last_class <= grant_class;
            if (is_dup && (dup_cnt != 8'hFF)) dup_cnt <= dup_cnt + 8'd1;
        end
    end
`else
    // Duplicate statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Bench for vote_session_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a session-level model of the voting rules.
module tb_vote_session_ctrl;

    localparam int WINDOW = 48;
    localparam int W_NP   = 1;
    localparam int W_VIP  = 4;
    localparam int W_VVIP = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       start = 1'b0;
    logic       close = 1'b0;
    logic [7:0] threshold = 8'd0;
    logic [7:0] tally;
    logic       pass;
    logic       busy;
    logic       done;
`ifdef VOTE_DUP_STATS_EN
    logic [7:0] dup_cnt;
    logic [1:0] last_class;
`endif

    vote_session_ctrl_if vif ();

    vote_session_ctrl #(
        .WINDOW (WINDOW),
        .W_NP   (W_NP),
        .W_VIP  (W_VIP),
        .W_VVIP (W_VVIP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .close      (close),
        .threshold  (threshold),
        .votes      (vif),
        .tally      (tally),
        .pass       (pass),
        .busy       (busy),
        .done       (done)
`ifdef VOTE_DUP_STATS_EN
        ,
        .dup_cnt    (dup_cnt),
        .last_class (last_class)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Session model: phase 0 idle, 1 accepting votes, 2 closing, 3 result published
    int m_phase, m_tally, m_thr, m_open_cycles, m_ptr, m_pass, m_dup, m_last;
    bit m_np [32];
    bit m_vip [8];
    bit m_vvip;
    int grant_log [$];

    task automatic model_reset();
        m_phase = 0; m_tally = 0; m_thr = 0; m_open_cycles = 0;
        m_ptr = 0; m_pass = 0; m_dup = 0; m_last = 0; m_vvip = 0;
        foreach (m_np[i]) m_np[i] = 0;
        foreach (m_vip[i]) m_vip[i] = 0;
    endtask

    int g, cls, s_start, s_close, s_thr, s_np_id, s_vip_id;
    bit reqs [3];
    bit seen;
    int weight;

    always begin
        @(negedge clk);
        if (!reset) model_reset();
        reqs[0] = vif.np_req; reqs[1] = vif.vip_req; reqs[2] = vif.vvip_req;
        g = -1;
        if (reset && m_phase == 1)
            for (int k = 0; k < 3; k++) begin
                cls = (m_ptr + k) % 3;
                if (g < 0 && reqs[cls]) g = cls;
            end
        check_output("np_ack", vif.np_ack, g == 0);
        check_output("vip_ack", vif.vip_ack, g == 1);
        check_output("vvip_ack", vif.vvip_ack, g == 2);
        check_output("busy", busy, m_phase == 1);
        check_output("done", done, m_phase == 3);
        check_output("tally", tally, m_tally);
        if (m_phase == 3) check_output("pass", pass, m_pass);
`ifdef VOTE_DUP_STATS_EN
        check_output("dup_cnt", dup_cnt, m_dup);
        check_output("last_class", last_class, m_last);
`endif
        if (g >= 0) grant_log.push_back(g);
        s_start = start; s_close = close; s_thr = threshold;
        s_np_id = vif.np_id; s_vip_id = vif.vip_id;
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            case (m_phase)
                0, 3: if (s_start) begin
                    m_phase = 1; m_tally = 0; m_open_cycles = 0; m_thr = s_thr; m_dup = 0; m_vvip = 0;
                    foreach (m_np[i]) m_np[i] = 0;
                    foreach (m_vip[i]) m_vip[i] = 0;
                end
                1: begin
                    if (g >= 0) begin
                        m_ptr = (g + 1) % 3;
                        m_last = g;
                        seen = (g == 0) ? m_np[s_np_id] : (g == 1) ? m_vip[s_vip_id] : m_vvip;
                        weight = (g == 0) ? W_NP : (g == 1) ? W_VIP : W_VVIP;
                        if (seen) begin
                            m_dup = (m_dup < 255) ? m_dup + 1 : 255;
                        end else begin
                            if (g == 0) m_np[s_np_id] = 1;
                            else if (g == 1) m_vip[s_vip_id] = 1;
                            else m_vvip = 1;
                            m_tally = (m_tally + weight > 255) ? 255 : m_tally + weight;
                        end
                    end
                    m_open_cycles++;
                    if (s_close || m_open_cycles == WINDOW) m_phase = 2;
                end
                2: begin
                    m_pass = (m_tally >= m_thr);
                    m_phase = 3;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // All directed tasks begin and end 1 time unit after a rising edge.
    task automatic set_req(input int c, input bit val, input int id);
        case (c)
            0: begin vif.np_req = val; vif.np_id = 5'(id); end
            1: begin vif.vip_req = val; vif.vip_id = 3'(id); end
            default: vif.vvip_req = val;
        endcase
    endtask

    task automatic apply_vote(input int c, input int id);
        bit got = 0;
        int waited = 0;
        set_req(c, 1'b1, id);
        while (!got && waited < 200) begin
            @(negedge clk);
            got = (c == 0) ? vif.np_ack : (c == 1) ? vif.vip_ack : vif.vvip_ack;
            waited++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("[TB] FAIL ack_timeout class=%0d actual=no_ack expected=ack", c);
        end
        @(posedge clk); #1;
        set_req(c, 1'b0, id);
    endtask

    task automatic start_session(input int thr);
        start = 1'b1;
        threshold = 8'(thr);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic close_session();
        close = 1'b1;
        @(posedge clk); #1;
        close = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    bit a0, a1, a2, b;

    initial begin
        vif.np_req = 0; vif.np_id = 0; vif.vip_req = 0; vif.vip_id = 0; vif.vvip_req = 0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check_output("reset_tally", tally, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_done", done, 0);
        check_output("reset_np_ack", vif.np_ack, 0);

        // Three normal votes and one VIP vote, then close: 3*1 + 4 = 7, below 20.
        start_session(20);
        apply_vote(0, 0); apply_vote(0, 1); apply_vote(0, 2); apply_vote(1, 3);
        check_output("t1_tally", tally, 7);
        close_session();
        check_output("t1_done", done, 1);
        check_output("t1_pass", pass, 0);

        // Duplicates are acked but not counted: 16 + 1 = 17 >= 16.
        start_session(16);
        check_output("t2_tally_cleared", tally, 0);
        check_output("t2_busy", busy, 1);
        repeat (2) fork apply_vote(2, 0); apply_vote(0, 5); join
        close_session();
        check_output("t2_tally", tally, 17);
        check_output("t2_pass", pass, 1);
`ifdef VOTE_DUP_STATS_EN
        check_output("t2_dup_cnt", dup_cnt, 2);
`endif

        // Continuous requests from every class rotate normal, VIP, VVIP.
        reset_dut();
        grant_log.delete();
        start_session(0);
        fork
            for (int i = 0; i < 4; i++) apply_vote(0, 10 + i);
            for (int i = 0; i < 4; i++) apply_vote(1, i);
            repeat (4) apply_vote(2, 0);
        join
        check_output("t3_grants", grant_log.size(), 12);
        for (int i = 0; i < 6; i++)
            if (i < grant_log.size()) check_output("t3_order", grant_log[i], i % 3);
        check_output("t3_tally", tally, 36);
        close_session();

        // Every voter votes once: 32 + 32 + 16 = 80.
        start_session(80);
        fork
            for (int i = 0; i < 32; i++) apply_vote(0, i);
            for (int i = 0; i < 8; i++) apply_vote(1, i);
            apply_vote(2, 0);
        join
        close_session();
        check_output("t5_tally", tally, 80);
        check_output("t5_pass", pass, 1);
        start_session(0);
        check_output("t5_restart_tally", tally, 0);
        check_output("t5_restart_busy", busy, 1);

        // Reach tally 12, then reset with a request pending.
        for (int i = 0; i < 4; i++) apply_vote(0, i);
        apply_vote(1, 0); apply_vote(1, 1);
        check_output("t6_tally", tally, 12);
        set_req(0, 1'b1, 20);
        #1 check_output("t6_ack_before", vif.np_ack, 1);
        #1 reset = 1'b0;
        #1;
        check_output("t6_ack_after", vif.np_ack, 0);
        check_output("t6_busy_after", busy, 0);
        check_output("t6_tally_after", tally, 0);
        @(posedge clk); #1;
        set_req(0, 1'b0, 0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_output("t6_no_done", done, 0);

        // Timeout: a vote on the last of the WINDOW open cycles is counted.
        start_session(0);
        repeat (WINDOW - 1) begin @(posedge clk); #1; end
        check_output("t4_busy_last", busy, 1);
        set_req(0, 1'b1, 9);
        #1 check_output("t4_ack_last", vif.np_ack, 1);
        @(posedge clk); #1;
        set_req(0, 1'b0, 0);
        check_output("t4_closed", busy, 0);
        check_output("t4_tally", tally, 1);
        @(posedge clk); #1;
        check_output("t4_done", done, 1);
        check_output("t4_pass", pass, 1);

        // Random traffic honouring the hold-until-ack handshake.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            a0 = vif.np_ack; a1 = vif.vip_ack; a2 = vif.vvip_ack; b = busy;
            @(posedge clk); #1;
            start = 1'b0;
            close = 1'b0;
            if (!vif.np_req || a0) begin
                vif.np_req = ($urandom_range(0, 2) == 0);
                vif.np_id = 5'($urandom_range(0, 31));
            end
            if (!vif.vip_req || a1) begin
                vif.vip_req = ($urandom_range(0, 2) == 0);
                vif.vip_id = 3'($urandom_range(0, 7));
            end
            if (!vif.vvip_req || a2) vif.vvip_req = ($urandom_range(0, 5) == 0);
            if (!b && $urandom_range(0, 3) == 0) begin
                start = 1'b1;
                threshold = 8'($urandom_range(0, 90));
            end
            if (b ? ($urandom_range(0, 23) == 0) : ($urandom_range(0, 7) == 0)) close = 1'b1;
        end
        start = 1'b0; close = 1'b0;
        vif.np_req = 0; vif.vip_req = 0; vif.vvip_req = 0;
        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vote_session_ctrl.md
Name: vote_session_ctrl

Overview:
- Controls one voting session for the weighted-vote datapath. A session is opened, accepts votes, is closed, and its result is published.
- Three requester classes (normal, VIP, VVIP) submit votes over req/ack handshakes. A round-robin arbiter shares one weighted tally adder between them.
- Sticky per-voter bitmaps make duplicate votes harmless.
- At close, the block publishes the tally and a pass/fail against a threshold.

Parameters:
- WINDOW, 64: maximum OPEN duration in cycles before auto-close (legal 1..256).
- W_NP, 1: weight of one normal vote.
- W_VIP, 4: weight of one VIP vote.
- W_VVIP, 16: weight of the VVIP vote.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; opens a new session.
- close  in  1  one-cycle pulse; ends the OPEN session early.
- threshold  in  8  pass threshold; sampled on the accepted start.
- np_req  in  1  normal voter request.
- np_id  in  5  normal voter index 0..31.
- np_ack  out  1  normal vote accepted this cycle.
- vip_req  in  1  VIP request.
- vip_id  in  3  VIP index 0..7.
- vip_ack  out  1  VIP vote accepted this cycle.
- vvip_req  in  1  VVIP request.
- vvip_ack  out  1  VVIP vote accepted this cycle.
- tally  out  8  running/final weighted tally.
- pass  out  1  tally >= threshold; valid while done=1.
- busy  out  1  high in OPEN.
- done  out  1  high in DONE.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; tally=0, pass=0, busy=0, done=0, all acks=0.
  - Bitmaps (32b normal, 8b VIP, 1b VVIP) cleared; timer=0; rr pointer=normal; latched threshold=0.
- Reset mid-session aborts it with no result. Acks drop immediately on reset assertion.
- FSM states: IDLE, OPEN, CLOSE, DONE.
  - IDLE: start → OPEN. On that edge: clear bitmaps, tally=0, timer=0, latch threshold. close is ignored.
  - OPEN: busy=1; timer increments every cycle. Exit to CLOSE when close=1 or timer==WINDOW-1. start is ignored.
  - CLOSE: one cycle; pass <= (tally >= latched threshold); no acks.
  - DONE: done=1; tally and pass held. start → OPEN with the same clearing as from IDLE; close is ignored.
- Handshake:
  - Requester holds req and id stable until it sees ack.
  - ack is combinational: asserted only in OPEN, to exactly one requesting class.
  - The vote is taken on the clock edge where req&ack=1. The requester may present its next id on the following cycle.
- Arbitration:
  - Rotating priority, order normal→VIP→VVIP.
  - After a grant to class k, class k+1 (mod 3) becomes highest priority. With no grant, the pointer holds.
  - Maximum wait for a requesting class is 2 grants.
- Tally:
  - On an accepted vote whose bitmap bit is 0: set the bit, tally += class weight.
  - If the bit is already 1 (duplicate): still ack, tally unchanged.
  - New tally is visible the cycle after the accepting edge.
  - Maximum tally with default weights is 32+32+16=80. The adder saturates at 255 for non-default weights.
- Boundary cases:
  - A vote accepted on the final OPEN cycle (close or timeout) is counted.
  - close and timeout in the same cycle give a single transition.
  - If start and close are both asserted in IDLE, start wins.

Optional Feature:
- Macro VOTE_DUP_STATS_EN.
- Defined:
  - Adds output dup_cnt [7:0]: number of duplicate votes acked in the current session.
  - Saturates at 255, cleared on session open and on reset, held in DONE.
  - Adds output last_class [1:0]: class of the most recent grant (0=normal, 1=VIP, 2=VVIP), reset 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then start with threshold=20; normal ids 0,1,2 and VIP id 3 (one at a time); close → OPEN lasts 5 cycles; tally=7 after the last vote; done=1, pass=0.
- Start with threshold=16; VVIP vote plus normal id 5, twice each → duplicates acked; tally=17, pass=1 (dup_cnt=2 with VOTE_DUP_STATS_EN).
- All three classes request continuously from the first OPEN cycle → grant order normal, VIP, VVIP, normal, …; each ack lasts exactly one cycle.
- WINDOW=8, no close → CLOSE is entered after 8 OPEN cycles; a vote accepted on cycle 8 is included in tally.
- All 32 normal, 8 VIP and the VVIP voters vote, threshold=80 → tally=80, pass=1; a start in DONE clears tally to 0 and busy=1 next cycle.
- Assert reset=0 mid-OPEN with tally=12 → tally=0, busy=0 and acks=0 immediately; no done pulse.
